// File: rtl/gray_io_pkg.sv
// Shared definitions for the Gray counter board I/O blocks.
//   LED_W      : width of the board slide switch / LED bank
//   ST_*       : debounce FSM state encodings
//   high_mask  : mask of the switch bits that do not fit in an n-bit value
package gray_io_pkg;

    localparam int LED_W = 8;

    localparam logic ST_STABLE = 1'b0;
    localparam logic ST_SETTLE = 1'b1;

    typedef enum logic {
        S_STABLE = ST_STABLE,
        S_SETTLE = ST_SETTLE
    } sw_state_e;

    // Bits [LED_W-1:n] set, bits [n-1:0] clear. For n == LED_W the shift
    // empties the whole word, so the mask is zero and nothing is ever out of range.
    function automatic logic [LED_W-1:0] high_mask(input int n);
        logic [LED_W-1:0] m;
        m = {LED_W{1'b1}};
        m = m << n;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk    in          sampling clock
//   reset  in          synchronous active-high reset, clears both stages
//   d_i    in  WIDTH   asynchronous input bits
//   q_o    out WIDTH   synchronised bits, two clocks behind d_i
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Each bit is an independent synchroniser; no bit depends on another.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= d_i[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign q_o = sync_q;

endmodule

// File: rtl/switch_reader_param.sv
// Slide switch reader for the Gray counter board.
// Synchronises and debounces the 8 board switches, then narrows the settled
// pattern to an N-bit value (e.g. a load value for the N-bit counter).
// Ports:
//   clk           in       system clock, rising edge
//   reset         in       synchronous active-high reset
//   sw            in  8    raw slide switches (asynchronous, bouncy)
//   sw_value      out N    committed pattern bits [N-1:0]
//   sw_overrange  out 1    committed pattern has a 1 above bit N-1
//   sw_valid      out 1    one-cycle pulse when sw_value/sw_overrange update
module switch_reader_param
    import gray_io_pkg::*;
#(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] sw,
    output logic [N-1:0]     sw_value,
    output logic             sw_overrange,
    output logic             sw_valid
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LED_W-1:0] HI_MASK  = high_mask(N);

    generate
        if (N < 1 || N > LED_W) begin : g_bad_n
            $error("switch_reader_param: N must be in 1..8");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("switch_reader_param: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic [LED_W-1:0] sw_sync;

    sync_2ff #(
        .WIDTH (LED_W)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sw),
        .q_o   (sw_sync)
    );

    sw_state_e        state_q;
    logic [LED_W-1:0] cand_q;
    logic [LED_W-1:0] comm_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     value_q;
    logic             ovr_q;
    logic             valid_q;

    // Debounce FSM. The full 8-bit pattern is compared against the committed
    // one, so a change confined to the out-of-range bits still commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_STABLE;
            cand_q  <= '0;
            comm_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_STABLE: begin
                    if (sw_sync != comm_q) begin
                        state_q <= S_SETTLE;
                        cand_q  <= sw_sync;
                        cnt_q   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (sw_sync == comm_q) begin
                        // Bounced back to the committed pattern: drop the candidate.
                        state_q <= S_STABLE;
                    end else if (sw_sync != cand_q) begin
                        // New candidate: restart the hold window.
                        cand_q <= sw_sync;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_STABLE;
                        comm_q  <= cand_q;
                        value_q <= cand_q[N-1:0];
                        ovr_q   <= |(cand_q & HI_MASK);
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= S_STABLE;
            endcase
        end
    end

    assign sw_value     = value_q;
    assign sw_overrange = ovr_q;
    assign sw_valid     = valid_q;

endmodule
